// File: rtl/mux12_4_4.sv
// Registered 12-to-1 selector for WIDTH-bit words; codes 12..15 load OOR_VALUE.
// Optional feature: define MUX12_4_4_SEL_ERR_EN to add the registered sel_err output.
module mux12_4_4 #(
    parameter int unsigned           WIDTH     = 4,
    parameter logic [WIDTH-1:0]      OOR_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    input  logic [WIDTH-1:0] D5,
    input  logic [WIDTH-1:0] D6,
    input  logic [WIDTH-1:0] D7,
    input  logic [WIDTH-1:0] D8,
    input  logic [WIDTH-1:0] D9,
    input  logic [WIDTH-1:0] D10,
    input  logic [WIDTH-1:0] D11,
    input  logic [3:0]       Sin,
`ifdef MUX12_4_4_SEL_ERR_EN
    output logic             sel_err,
`endif
    output logic [WIDTH-1:0] Dout
);

    localparam int unsigned NUM_SRC = 12;

    logic [WIDTH-1:0] mux_c;
    logic             oor_c;

    // Full decode of all 16 codes so undefined selects never produce X.
    always_comb begin
        mux_c = OOR_VALUE;
        oor_c = (Sin >= 4'(NUM_SRC));
        case (Sin)
            4'd0:    mux_c = D0;
            4'd1:    mux_c = D1;
            4'd2:    mux_c = D2;
            4'd3:    mux_c = D3;
            4'd4:    mux_c = D4;
            4'd5:    mux_c = D5;
            4'd6:    mux_c = D6;
            4'd7:    mux_c = D7;
            4'd8:    mux_c = D8;
            4'd9:    mux_c = D9;
            4'd10:   mux_c = D10;
            4'd11:   mux_c = D11;
            default: mux_c = OOR_VALUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Dout <= '0;
        end else begin
            Dout <= mux_c;
        end
    end

`ifdef MUX12_4_4_SEL_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= oor_c;
        end
    end
`else
    logic unused_oor_c;
    assign unused_oor_c = oor_c;
`endif

endmodule

// File: tb/tb_mux12_4_4.sv
// Directed, table-driven bench for mux12_4_4 (default parameters).
module tb_mux12_4_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d [12];
    logic [3:0] sin;
    logic [3:0] dout;
    logic       sel_err_w;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    mux12_4_4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D0    (d[0]),
        .D1    (d[1]),
        .D2    (d[2]),
        .D3    (d[3]),
        .D4    (d[4]),
        .D5    (d[5]),
        .D6    (d[6]),
        .D7    (d[7]),
        .D8    (d[8]),
        .D9    (d[9]),
        .D10   (d[10]),
        .D11   (d[11]),
        .Sin   (sin),
`ifdef MUX12_4_4_SEL_ERR_EN
        .sel_err (sel_err_w),
`endif
        .Dout  (dout)
    );

`ifndef MUX12_4_4_SEL_ERR_EN
    assign sel_err_w = 1'b0;
`endif

    typedef struct {
        logic [3:0] sin;
        logic [3:0] exp_dout;
        logic       exp_err;
    } vec_t;

    vec_t vecs [18];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_err(input string name, input logic exp);
`ifdef MUX12_4_4_SEL_ERR_EN
        total++;
        if (sel_err_w !== exp) begin
            bad++;
            $display("FAIL %s: sel_err got %b expected %b", name, sel_err_w, exp);
        end
`endif
    endtask

    initial begin
        vecs = '{
            '{4'd8,  4'h8, 1'b0}, '{4'd2,  4'hC, 1'b0}, '{4'd10, 4'hB, 1'b0},
            '{4'd3,  4'h8, 1'b0}, '{4'd0,  4'h3, 1'b0}, '{4'd7,  4'h1, 1'b0},
            '{4'd1,  4'h1, 1'b0}, '{4'd9,  4'h5, 1'b0}, '{4'd5,  4'h1, 1'b0},
            '{4'd6,  4'h9, 1'b0}, '{4'd11, 4'h1, 1'b0}, '{4'd4,  4'h3, 1'b0},
            '{4'd13, 4'h0, 1'b1}, '{4'd14, 4'h0, 1'b1}, '{4'd12, 4'h0, 1'b1},
            '{4'd15, 4'h0, 1'b1}, '{4'd2,  4'hC, 1'b0}, '{4'd8,  4'h8, 1'b0}
        };
        d = '{4'h3, 4'h1, 4'hC, 4'h8, 4'h3, 4'h1, 4'h9, 4'h1, 4'h8, 4'h5, 4'hB, 4'h1};

        // Reset for two edges with Sin=8, then release.
        rst_n = 1'b0;
        sin   = 4'd8;
        step();
        step();
        check("reset_dout", dout, 4'h0);
        check_err("reset_err", 1'b0);
        rst_n = 1'b1;
        step();
        check("reset_release", dout, 4'h8);

        // Sweep: in-range, out-of-range, and back in range.
        for (int i = 0; i < 18; i++) begin
            sin = vecs[i].sin;
            #1;
            if (i > 0 && vecs[i].sin != vecs[i-1].sin)
                check($sformatf("hold_before_edge[%0d]", i), dout, vecs[i-1].exp_dout);
            step();
            check($sformatf("sweep[%0d] sin=%0d", i, vecs[i].sin), dout, vecs[i].exp_dout);
            check_err($sformatf("sweep_err[%0d]", i), vecs[i].exp_err);
        end

        // Data change under constant select; unselected input has no effect.
        sin = 4'd9;
        step();
        check("d9_before", dout, 4'h5);
        d[9] = 4'hA;
        d[8] = 4'h7;
        #1;
        check("d9_no_comb_path", dout, 4'h5);
        step();
        check("d9_after", dout, 4'hA);
        d[8] = 4'h2;
        step();
        check("d8_ignored", dout, 4'hA);

        // Simultaneous change of select and selected data.
        sin  = 4'd3;
        d[3] = 4'hE;
        step();
        check("simul_change", dout, 4'hE);
        d[3] = 4'h8;

        // Mid-run reset for one edge.
        sin = 4'd6;
        step();
        check("midrun_pre", dout, 4'h9);
        rst_n = 1'b0;
        step();
        check("midrun_reset", dout, 4'h0);
        rst_n = 1'b1;
        step();
        check("midrun_release", dout, 4'h9);

        // Reset overrides an out-of-range select too.
        sin = 4'd14;
        step();
        check_err("oor_pre_reset", 1'b1);
        rst_n = 1'b0;
        step();
        check("oor_reset", dout, 4'h0);
        check_err("oor_reset_err", 1'b0);
        rst_n = 1'b1;
        sin = 4'd10;
        step();
        check("final", dout, 4'hB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
